alu_arbiter: RTL and testbench

Shares the single 32-bit integer ALU between two requesters (requester 0: execute stage; requester 1: address/branch-compare unit) through valid/ready handshakes. Arbitration is round-robin. The ALU core is instantiated inside the block, and one result register decouples the ALU from the consumers, giving one-cycle latency at one operation per cycle. The block sits between the decode/issue logic and the writeback paths of both requesters.

---
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arbiter.sv | 97 +++++++++
 tb/tb_alu_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Handshake bundle between the two ALU requesters and the shared arbiter.
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_ctl;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [4:0]  req0_sa;

   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_ctl;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [4:0]  req1_sa;

   logic        rsp0_valid;
   logic        rsp0_ready;
   logic        rsp1_valid;
   logic        rsp1_ready;
   logic [31:0] rsp_data;
   logic        busy;

   modport master (
      output req0_valid, req0_ctl, req0_a, req0_b, req0_sa,
      output req1_valid, req1_ctl, req1_a, req1_b, req1_sa,
      output rsp0_ready, rsp1_ready,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp1_valid, rsp_data, busy
   );

   modport slave (
      input  req0_valid, req0_ctl, req0_a, req0_b, req0_sa,
      input  req1_valid, req1_ctl, req1_a, req1_b, req1_sa,
      input  rsp0_ready, rsp1_ready,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp1_valid, rsp_data, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters,
// with a single result register giving one-cycle latency.
module alu_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   alu_arbiter_if.slave bus
);

   logic        full_q,  full_d;
   logic        owner_q, owner_d;
   logic        prio_q,  prio_d;
   logic [31:0] data_q,  data_d;

   logic        drain;
   logic        can_accept;
   logic        grant;
   logic        req0_ready;
   logic        req1_ready;
   logic        accept;
   logic [4:0]  sel_ctl;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [4:0]  sel_sa;

   // Bit 4 of ctl is a don't-care in every pattern.
   function automatic logic [31:0] alu_result(
      input logic [4:0]  ctl,
      input logic [31:0] a,
      input logic [31:0] b,
      input logic [4:0]  sa
   );
      logic [31:0] r;
      casez (ctl)
         5'b?0010: r = a + b;
         5'b?0110: r = a - b;
         5'b?0000: r = a & b;
         5'b?0001: r = a | b;
         5'b?0011: r = a ^ b;
         5'b?0111: r = {31'b0, (a < b)};
         5'b?1000: r = b << sa;
         5'b?1100: r = b >> sa;
         default:  r = '0;
      endcase
      return r;
   endfunction

   // Arbitration, handshake and next-state for the result register.
   always_comb begin
      drain      = full_q & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
      can_accept = ~full_q | drain;
      grant      = (bus.req0_valid & bus.req1_valid) ? prio_q : bus.req1_valid;
      req0_ready = can_accept & bus.req0_valid & ~grant;
      req1_ready = can_accept & bus.req1_valid & grant;
      accept     = req0_ready | req1_ready;

      sel_ctl = grant ? bus.req1_ctl : bus.req0_ctl;
      sel_a   = grant ? bus.req1_a   : bus.req0_a;
      sel_b   = grant ? bus.req1_b   : bus.req0_b;
      sel_sa  = grant ? bus.req1_sa  : bus.req0_sa;

      full_d  = full_q;
      owner_d = owner_q;
      prio_d  = prio_q;
      data_d  = data_q;
      if (accept) begin
         data_d  = alu_result(sel_ctl, sel_a, sel_b, sel_sa);
         owner_d = grant;
         full_d  = 1'b1;
         prio_d  = ~grant;
      end else if (drain) begin
         full_d  = 1'b0;
      end
   end

   // Result register and arbitration state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q  <= 1'b0;
         owner_q <= 1'b0;
         prio_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         full_q  <= full_d;
         owner_q <= owner_d;
         prio_q  <= prio_d;
         data_q  <= data_d;
      end
   end

   assign bus.req0_ready = req0_ready;
   assign bus.req1_ready = req1_ready;
   assign bus.rsp0_valid = full_q & ~owner_q;
   assign bus.rsp1_valid = full_q & owner_q;
   assign bus.rsp_data   = data_q;
   assign bus.busy       = full_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

   logic clk;
   logic rst_n;
   int unsigned errors;
   int unsigned checks;

   alu_arbiter_if bus ();

   alu_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Op table for requester 1: ctl, a, b, sa, expected
   logic [4:0]  op_ctl [0:7] = '{5'd6, 5'd7, 5'd7, 5'd8, 5'd12, 5'd5, 5'h12, 5'd3};
   logic [31:0] op_a   [0:7] = '{32'd3, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd3, 32'd10, 32'h0000F0F0};
   logic [31:0] op_b   [0:7] = '{32'd5, 32'd1, 32'd2, 32'd1, 32'h80000000, 32'd4, 32'd20, 32'h0000FF00};
   logic [4:0]  op_sa  [0:7] = '{5'd4, 5'd4, 5'd4, 5'd31, 5'd31, 5'd4, 5'd4, 5'd4};
   logic [31:0] op_exp [0:7] = '{32'hFFFFFFFE, 32'd0, 32'd1, 32'h80000000, 32'd1, 32'd0, 32'd30, 32'h00000FF0};

   // Round-robin ops: requester 0 then requester 1
   logic [4:0]  rr_ctl [0:1][0:1] = '{'{5'd2, 5'd0}, '{5'd1, 5'd3}};
   logic [31:0] rr_a   [0:1][0:1] = '{'{32'd1, 32'h0000F0F0}, '{32'd1, 32'hF}};
   logic [31:0] rr_b   [0:1][0:1] = '{'{32'd1, 32'h0000FF00}, '{32'd2, 32'h3}};
   logic [31:0] rr_exp [0:1][0:1] = '{'{32'd2, 32'h0000F000}, '{32'd3, 32'hC}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] s);
      bus.req0_valid = v; bus.req0_ctl = c; bus.req0_a = a; bus.req0_b = b; bus.req0_sa = s;
   endtask

   task automatic set_req1(input logic v, input logic [4:0] c, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] s);
      bus.req1_valid = v; bus.req1_ctl = c; bus.req1_a = a; bus.req1_b = b; bus.req1_sa = s;
   endtask

   initial begin
      int k [0:1];
      int unsigned g;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      set_req0(1'b0, '0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0, '0);
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;

      // Reset state
      #22;
      chk("rst_busy",    32'(bus.busy),       32'd0);
      chk("rst_rsp0_v",  32'(bus.rsp0_valid), 32'd0);
      chk("rst_rsp1_v",  32'(bus.rsp1_valid), 32'd0);
      chk("rst_data",    bus.rsp_data,        32'd0);
      chk("rst_req0_r",  32'(bus.req0_ready), 32'd0);
      chk("rst_req1_r",  32'(bus.req1_ready), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Single op via requester 0
      bus.rsp0_ready = 1'b1;
      set_req0(1'b1, 5'd2, 32'd7, 32'd5, 5'd3);
      #1;
      chk("single_req0_r", 32'(bus.req0_ready), 32'd1);
      chk("single_req1_r", 32'(bus.req1_ready), 32'd0);
      tick();
      bus.req0_valid = 1'b0;
      chk("single_rsp0_v", 32'(bus.rsp0_valid), 32'd1);
      chk("single_rsp1_v", 32'(bus.rsp1_valid), 32'd0);
      chk("single_data",   bus.rsp_data,        32'd12);
      chk("single_busy",   32'(bus.busy),       32'd1);

      // Op coverage via requester 1, one accept per cycle
      bus.rsp1_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_req1(1'b1, op_ctl[i], op_a[i], op_b[i], op_sa[i]);
         #1;
         chk($sformatf("op%0d_req1_r", i), 32'(bus.req1_ready), 32'd1);
         tick();
         chk($sformatf("op%0d_rsp1_v", i), 32'(bus.rsp1_valid), 32'd1);
         chk($sformatf("op%0d_data", i),   bus.rsp_data,        op_exp[i]);
      end
      bus.req1_valid = 1'b0;
      tick();
      chk("drain_busy", 32'(bus.busy), 32'd0);

      // Round-robin: both valid, expect 0,1,0,1
      k[0] = 0;
      k[1] = 0;
      set_req0(1'b1, rr_ctl[0][0], rr_a[0][0], rr_b[0][0], 5'd0);
      set_req1(1'b1, rr_ctl[1][0], rr_a[1][0], rr_b[1][0], 5'd0);
      for (int s = 0; s < 4; s++) begin
         g = s % 2;
         #1;
         chk($sformatf("rr%0d_req0_r", s), 32'(bus.req0_ready), 32'(g == 0));
         chk($sformatf("rr%0d_req1_r", s), 32'(bus.req1_ready), 32'(g == 1));
         tick();
         chk($sformatf("rr%0d_rsp0_v", s), 32'(bus.rsp0_valid), 32'(g == 0));
         chk($sformatf("rr%0d_rsp1_v", s), 32'(bus.rsp1_valid), 32'(g == 1));
         chk($sformatf("rr%0d_data", s),   bus.rsp_data,        rr_exp[g][k[g]]);
         k[g]++;
         if (g == 0) begin
            if (k[0] < 2) set_req0(1'b1, rr_ctl[0][k[0]], rr_a[0][k[0]], rr_b[0][k[0]], 5'd0);
            else          bus.req0_valid = 1'b0;
         end else begin
            if (k[1] < 2) set_req1(1'b1, rr_ctl[1][k[1]], rr_a[1][k[1]], rr_b[1][k[1]], 5'd0);
            else          bus.req1_valid = 1'b0;
         end
      end
      tick();
      chk("rr_end_busy", 32'(bus.busy), 32'd0);

      // Backpressure: req0 result held, req1 stalls
      bus.rsp0_ready = 1'b0;
      set_req0(1'b1, 5'd1, 32'h000000F0, 32'h0000000F, 5'd0);
      #1;
      chk("bp_req0_r", 32'(bus.req0_ready), 32'd1);
      tick();
      bus.req0_valid = 1'b0;
      set_req1(1'b1, 5'd2, 32'd1, 32'd2, 5'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp%0d_req1_r", c),  32'(bus.req1_ready), 32'd0);
         chk($sformatf("bp%0d_data", c),    bus.rsp_data,        32'h000000FF);
         chk($sformatf("bp%0d_busy", c),    32'(bus.busy),       32'd1);
         chk($sformatf("bp%0d_rsp0_v", c),  32'(bus.rsp0_valid), 32'd1);
         tick();
      end
      bus.rsp0_ready = 1'b1;
      #1;
      chk("bp_release_req1_r", 32'(bus.req1_ready), 32'd1);
      tick();
      bus.req1_valid = 1'b0;
      chk("bp_rsp1_v", 32'(bus.rsp1_valid), 32'd1);
      chk("bp_rsp0_v", 32'(bus.rsp0_valid), 32'd0);
      chk("bp_data",   bus.rsp_data,        32'd3);
      tick();

      // Reset mid-operation
      bus.rsp1_ready = 1'b0;
      set_req1(1'b1, 5'd3, 32'h000000AA, 32'h00000055, 5'd0);
      #1;
      chk("mr_req1_r", 32'(bus.req1_ready), 32'd1);
      tick();
      bus.req1_valid = 1'b0;
      chk("mr_rsp1_v", 32'(bus.rsp1_valid), 32'd1);
      chk("mr_data",   bus.rsp_data,        32'h000000FF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_rst_rsp1_v", 32'(bus.rsp1_valid), 32'd0);
      chk("mr_rst_busy",   32'(bus.busy),       32'd0);
      chk("mr_rst_data",   bus.rsp_data,        32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.rsp1_ready = 1'b1;
      set_req1(1'b1, 5'd6, 32'd10, 32'd3, 5'd0);
      #1;
      chk("post_rst_req1_r", 32'(bus.req1_ready), 32'd1);
      tick();
      bus.req1_valid = 1'b0;
      chk("post_rst_rsp1_v", 32'(bus.rsp1_valid), 32'd1);
      chk("post_rst_data",   bus.rsp_data,        32'd7);
      tick();

      // After reset prio is 0: tie goes to requester 0
      set_req0(1'b1, 5'd2, 32'd1, 32'd1, 5'd0);
      set_req1(1'b1, 5'd2, 32'd2, 32'd2, 5'd0);
      #1;
      chk("post_rst_tie_req0_r", 32'(bus.req0_ready), 32'd1);
      chk("post_rst_tie_req1_r", 32'(bus.req1_ready), 32'd0);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
